// File: rtl/sdram_req_queue.sv
// sdram_req_queue: FIFO-buffered request sequencer driving an AHB-style SDRAM controller port; watchdog abort via SDRAM_REQ_QUEUE_TIMEOUT_EN
module sdram_req_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic        in_HCLK,
    input  logic        in_HRESET,
    input  logic        in_req_valid,
    output logic        out_req_ready,
    input  logic        in_req_write,
    input  logic [31:0] in_req_addr,
    input  logic [31:0] in_req_wdata,
    output logic        out_rsp_valid,
    output logic [31:0] out_rsp_rdata,
    output logic        out_rsp_err,
    output logic        out_err_timeout,
    output logic        out_busy,
    output logic        out_HSEL,
    output logic        out_HWRITE,
    output logic [31:0] out_HADDR,
    output logic [31:0] out_HWDATA,
    input  logic        in_HREADY,
    input  logic [31:0] in_HRDATA
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t        state;
    logic   [64:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic   [AW:0] count;
    logic          push, pop, abort;

    assign out_req_ready = (count != FULL) && in_HRESET;
    assign out_busy      = in_HRESET && ((count != '0) || (state != IDLE));
    assign push          = in_req_valid && out_req_ready;
    assign pop           = (state != ISSUE) && (count != '0);

    // FIFO storage and pointers; pop only sees entries pushed on earlier edges
    always_ff @(posedge in_HCLK) begin
        if (!in_HRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {in_req_write, in_req_addr, in_req_wdata};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Transfer sequencer: load head, hold until HREADY or abort, then one gap cycle
    always_ff @(posedge in_HCLK) begin
        if (!in_HRESET) begin
            state         <= IDLE;
            out_HSEL      <= 1'b0;
            out_HWRITE    <= 1'b0;
            out_HADDR     <= '0;
            out_HWDATA    <= '0;
            out_rsp_valid <= 1'b0;
            out_rsp_rdata <= '0;
        end else begin
            out_rsp_valid <= 1'b0;
            if (pop) begin
                {out_HWRITE, out_HADDR, out_HWDATA} <= mem[rd_ptr];
                out_HSEL <= 1'b1;
                state    <= ISSUE;
            end else if (state == ISSUE && (in_HREADY || abort)) begin
                out_HSEL <= 1'b0;
                state    <= GAP;
                if (!out_HWRITE) begin
                    out_rsp_valid <= 1'b1;
                    out_rsp_rdata <= in_HREADY ? in_HRDATA : '0;
                end
            end else if (state == GAP) begin
                state <= IDLE;
            end
        end
    end

`ifdef SDRAM_REQ_QUEUE_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT);
    logic [WW-1:0] wd_cnt;

    assign abort = (state == ISSUE) && !in_HREADY && (wd_cnt == WW'(TIMEOUT - 1));

    // Watchdog: counts stalled ISSUE cycles, restarts on every new transfer
    always_ff @(posedge in_HCLK) begin
        if (!in_HRESET) begin
            wd_cnt          <= '0;
            out_err_timeout <= 1'b0;
            out_rsp_err     <= 1'b0;
        end else begin
            out_err_timeout <= abort;
            out_rsp_err     <= abort && !out_HWRITE;
            wd_cnt          <= pop ? '0 : (state == ISSUE && !in_HREADY) ? wd_cnt + 1'b1 : wd_cnt;
        end
    end
`else
    assign abort           = 1'b0;
    assign out_err_timeout = 1'b0;
    assign out_rsp_err     = 1'b0;
`endif
endmodule
